program_stream_tx: RTL and testbench
====================================

// Module: program_stream_tx
// PURPOSE
//  Byte-stream transmitter for the instruction-memory download protocol. On start_i it reads
//  N 32-bit words from a synchronous source memory and emits them one byte per clock as:
//  0xFE (start marker), 4N data bytes MSB-first, then 0xFF (end marker). Idle byte is 0x00.
//  Sits on the host/test side and drives the instruction-memory byte input; the line has no
//  backpressure, so the stream is gapless.
// PARAMETERS
//  ADDR_W  6  source word-address width; DEPTH = 2**ADDR_W words (64)
// PORTS
//  clk           in   1         clock, rising edge
//  reset         in   1         asynchronous, active-high
//  start_i       in   1         start request, sampled only in IDLE
//  num_words_i   in   ADDR_W+1  words to send, latched with start_i; values > DEPTH saturate to DEPTH
//  src_addr_o    out  ADDR_W    source word address (combinational from state)
//  src_rd_o      out  1         source read strobe; src_data_i is valid the cycle after src_rd_o
//  src_data_i    in   32        source read data, 1-cycle latency
//  byte_o        out  8         protocol byte; 0x00 when idle
//  byte_valid_o  out  1         high in START, DATA and END cycles
//  busy_o        out  1         high from the cycle after start acceptance through the END cycle
//  done_o        out  1         one-cycle pulse in the END cycle
//  err_o         out  1         sticky; set on abort, cleared on next accepted start
// BEHAVIOUR
//  Reset: state=IDLE; byte_o=0x00; byte_valid_o, busy_o, done_o, err_o, src_rd_o=0; src_addr_o=0;
//   word and byte counters = 0. Reset mid-stream abandons it immediately; no END marker is sent.
//  States: IDLE -> START -> DATA -> END -> IDLE.
//   IDLE : byte_o=0x00. start_i=1 in cycle T -> latch N (saturated), clear err_o, go START.
//   START: cycle T+1; byte_o=0xFE. If N=0 -> END, no reads; else src_rd_o=1, src_addr_o=0 -> DATA.
//   DATA : byte index k=0..3 per word i. k=0 passes src_data_i[31:24] through and captures
//     src_data_i[23:0]; k=1..3 emit captured [23:16], [15:8], [7:0].
//     In k=3 of word i with i+1<N: src_rd_o=1, src_addr_o=i+1 (prefetch, no bubble).
//     After k=3 of word N-1 -> END.
//   END  : byte_o=0xFF, byte_valid_o=1, done_o=1 -> IDLE next cycle.
//  Timeline, error-free: 0xFE at T+1, data bytes at T+2..T+1+4N, 0xFF at T+2+4N, 0x00 at T+3+4N.
//  Abort: the end marker must never appear inside data. In a k=0 cycle, if any byte of src_data_i
//   is 0xFF, emit 0xFF in that slot, set err_o, pulse done_o, and go to IDLE. That word is not
//   sent; 0xFE data bytes are legal and are sent unchanged.
//  start_i is ignored while busy_o=1. start_i in the END cycle is ignored. start_i in the
//   following IDLE cycle is accepted, so at least one 0x00 separates streams.
//  Counters: word index is ADDR_W+1 bits and compares against the saturated N. The address is
//   the low ADDR_W bits of the index. N=DEPTH reads addresses 0..DEPTH-1 with no wrap.
//  Outputs change only on clk edges, except byte_o in k=0 slots, which follows src_data_i.
// TESTING
//  N=1, mem[0]=0x00500093, start at T -> bytes FE,00,50,00,93,FF at T+1..T+6; done_o at T+6; err_o=0.
//  N=3, mem[0..2]=0x11223344,0x55667788,0x0A0B0C0D -> 14 contiguous valid bytes in MSB-first
//   order; src_rd_o asserts at T+1, T+5 and T+9 with addresses 0, 1, 2.
//  N=0 -> FE then FF on consecutive cycles; src_rd_o never asserts.
//  N=2, mem[1]=0xFFF00093 -> FE + 4 bytes of word 0, then FF at T+6; err_o=1; next start clears err_o.
//  num_words_i=100, ADDR_W=6 -> exactly 256 data bytes from addresses 0..63, then FF.
//  Assert reset during DATA -> byte_o=0x00 and byte_valid_o=0 immediately; no FF; a new start
//   after reset release runs a full stream.

Source files
------------

// File: rtl/program_stream_tx.sv
// Instruction-memory download transmitter: reads N words from a synchronous source
// memory and streams 0xFE, the data bytes MSB-first, then 0xFF, one byte per clock.
module program_stream_tx #(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_i,
  input  logic [ADDR_W:0]   num_words_i,
  output logic [ADDR_W-1:0] src_addr_o,
  output logic              src_rd_o,
  input  logic [31:0]       src_data_i,
  output logic [7:0]        byte_o,
  output logic              byte_valid_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o
);

  localparam int              DEPTH   = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE_W   = (ADDR_W + 1)'(1);

  localparam logic [7:0] START_MARK = 8'hFE;
  localparam logic [7:0] END_MARK   = 8'hFF;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_END
  } state_e;

  state_e            state_q;
  logic [ADDR_W:0]   word_q;
  logic [ADDR_W:0]   n_q;
  logic [1:0]        k_q;
  logic [23:0]       cap_q;
  logic              err_q;

  logic              word_has_end;
  logic              last_word;
  logic [ADDR_W:0]   n_sat;

  // A fetched word carrying 0xFF anywhere would fake an end marker, so it aborts the stream.
  assign word_has_end = (src_data_i[31:24] == END_MARK) || (src_data_i[23:16] == END_MARK) ||
                        (src_data_i[15:8]  == END_MARK) || (src_data_i[7:0]   == END_MARK);
  assign last_word    = (word_q + ONE_W) == n_q;
  assign n_sat        = (num_words_i > DEPTH_W) ? DEPTH_W : num_words_i;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values; blocking here would create order-dependent simulation races.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      word_q  <= '0;
      n_q     <= '0;
      k_q     <= '0;
      cap_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start_i) begin
            n_q     <= n_sat;
            err_q   <= 1'b0;
            word_q  <= '0;
            k_q     <= '0;
            state_q <= S_START;
          end
        end
        S_START: begin
          state_q <= (n_q == '0) ? S_END : S_DATA;
        end
        S_DATA: begin
          if (k_q == 2'd0) begin
            if (word_has_end) begin
              err_q   <= 1'b1;
              state_q <= S_IDLE;
            end else begin
              cap_q <= src_data_i[23:0];
              k_q   <= 2'd1;
            end
          end else if (k_q != 2'd3) begin
            k_q <= k_q + 2'd1;
          end else begin
            k_q <= 2'd0;
            if (last_word) begin
              state_q <= S_END;
            end else begin
              word_q <= word_q + ONE_W;
            end
          end
        end
        S_END: begin
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Outputs decode registered state; only the k=0 data slot looks through to src_data_i.
  // NOTE: every output gets a default first so no path through the case infers a latch.
  always_comb begin
    byte_o       = 8'h00;
    byte_valid_o = 1'b0;
    busy_o       = 1'b0;
    done_o       = 1'b0;
    src_rd_o     = 1'b0;
    src_addr_o   = '0;
    unique case (state_q)
      S_IDLE: ;
      S_START: begin
        byte_o       = START_MARK;
        byte_valid_o = 1'b1;
        busy_o       = 1'b1;
        src_rd_o     = (n_q != '0);
      end
      S_DATA: begin
        byte_valid_o = 1'b1;
        busy_o       = 1'b1;
        unique case (k_q)
          2'd0: begin
            byte_o = word_has_end ? END_MARK : src_data_i[31:24];
            done_o = word_has_end;
          end
          2'd1: byte_o = cap_q[23:16];
          2'd2: byte_o = cap_q[15:8];
          default: begin
            byte_o = cap_q[7:0];
            if (!last_word) begin
              src_rd_o   = 1'b1;
              src_addr_o = word_q[ADDR_W-1:0] + ADDR_W'(1);
            end
          end
        endcase
      end
      S_END: begin
        byte_o       = END_MARK;
        byte_valid_o = 1'b1;
        busy_o       = 1'b1;
        done_o       = 1'b1;
      end
      default: ;
    endcase
  end

  assign err_o = err_q;

endmodule

// File: tb/tb_program_stream_tx.sv
// Self-checking bench for program_stream_tx: a behavioural memory plus a byte-list
// reference model derived from the download protocol rules.
module tb_program_stream_tx;

  localparam int ADDR_W = 6;
  localparam int DEPTH  = 64;

  logic              clk = 1'b0;
  logic              reset;
  logic              start_i;
  logic [ADDR_W:0]   num_words_i;
  logic [ADDR_W-1:0] src_addr_o;
  logic              src_rd_o;
  logic [31:0]       src_data_i;
  logic [7:0]        byte_o;
  logic              byte_valid_o;
  logic              busy_o;
  logic              done_o;
  logic              err_o;

  logic [31:0] mem [DEPTH];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  program_stream_tx #(.ADDR_W(ADDR_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .start_i      (start_i),
    .num_words_i  (num_words_i),
    .src_addr_o   (src_addr_o),
    .src_rd_o     (src_rd_o),
    .src_data_i   (src_data_i),
    .byte_o       (byte_o),
    .byte_valid_o (byte_valid_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .err_o        (err_o)
  );

  // Source memory with one-cycle read latency.
  always @(posedge clk) if (src_rd_o) src_data_i <= mem[src_addr_o];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] scrub(input logic [31:0] w);
    logic [31:0] r = w;
    for (int b = 0; b < 4; b++) if (r[8*b +: 8] == 8'hFF) r[8*b +: 8] = 8'hFE;
    return r;
  endfunction

  task automatic fill_mem(input bit allow_ff);
    for (int i = 0; i < DEPTH; i++) mem[i] = allow_ff ? $urandom : scrub($urandom);
  endtask

  // Runs one stream and compares it against the protocol model.
  task automatic run_stream(input int nw_req, input bit poke_start, input string tag);
    int          n;
    logic [7:0]  exp_q[$];
    int          exp_rd_pos[$];
    bit          exp_err;
    logic [7:0]  got_q[$];
    int          rd_pos[$];
    int          rd_addr[$];
    int          done_idx[$];
    int          busy_bad;
    int          idx;
    logic [31:0] w;

    n = (nw_req > DEPTH) ? DEPTH : nw_req;
    exp_err = 1'b0;
    exp_q.push_back(8'hFE);
    for (int i = 0; i < n; i++) begin
      exp_rd_pos.push_back(4 * i);
      w = mem[i];
      if (w[31:24] == 8'hFF || w[23:16] == 8'hFF || w[15:8] == 8'hFF || w[7:0] == 8'hFF) begin
        exp_q.push_back(8'hFF);
        exp_err = 1'b1;
        break;
      end
      for (int b = 3; b >= 0; b--) exp_q.push_back(w[8*b +: 8]);
    end
    if (!exp_err) exp_q.push_back(8'hFF);

    @(negedge clk);
    start_i     = 1'b1;
    num_words_i = (ADDR_W + 1)'(nw_req);
    @(negedge clk);
    start_i = 1'b0;
    check({tag, " err_cleared"}, 32'(err_o), 32'h0);

    busy_bad = 0;
    idx      = 0;
    while (byte_valid_o && idx < 400) begin
      got_q.push_back(byte_o);
      if (src_rd_o) begin
        rd_pos.push_back(idx);
        rd_addr.push_back(int'(src_addr_o));
      end
      if (done_o) done_idx.push_back(idx);
      if (!busy_o) busy_bad++;
      start_i = poke_start && (idx == 2);
      idx++;
      @(negedge clk);
    end
    start_i = 1'b0;

    check({tag, " length"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("%s byte[%0d]", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
    check({tag, " busy_during"}, 32'(busy_bad), 32'h0);
    check({tag, " reads"}, 32'(rd_pos.size()), 32'(exp_rd_pos.size()));
    for (int i = 0; i < exp_rd_pos.size() && i < rd_pos.size(); i++) begin
      check($sformatf("%s rd_pos[%0d]", tag, i), 32'(rd_pos[i]), 32'(exp_rd_pos[i]));
      check($sformatf("%s rd_addr[%0d]", tag, i), 32'(rd_addr[i]), 32'(i));
    end
    check({tag, " done_count"}, 32'(done_idx.size()), 32'h1);
    if (done_idx.size() > 0) check({tag, " done_slot"}, 32'(done_idx[0]), 32'(exp_q.size() - 1));
    check({tag, " idle_byte"}, 32'(byte_o), 32'h0);
    check({tag, " idle_busy"}, 32'(busy_o), 32'h0);
    check({tag, " err"}, 32'(err_o), 32'(exp_err));
  endtask

  initial begin
    reset       = 1'b1;
    start_i     = 1'b0;
    num_words_i = '0;
    src_data_i  = '0;
    fill_mem(1'b0);
    #1;
    check("reset byte", 32'(byte_o), 32'h0);
    check("reset valid", 32'(byte_valid_o), 32'h0);
    check("reset busy", 32'(busy_o), 32'h0);
    check("reset done", 32'(done_o), 32'h0);
    check("reset err", 32'(err_o), 32'h0);
    check("reset rd", 32'(src_rd_o), 32'h0);
    check("reset addr", 32'(src_addr_o), 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    mem[0] = 32'h00500093;
    run_stream(1, 1'b0, "n1");

    mem[0] = 32'h11223344; mem[1] = 32'h55667788; mem[2] = 32'h0A0B0C0D;
    run_stream(3, 1'b1, "n3");

    run_stream(0, 1'b0, "n0");

    mem[0] = 32'h01020304; mem[1] = 32'hFFF00093;
    run_stream(2, 1'b0, "abort_top");
    mem[1] = 32'h55FE66FF;
    run_stream(2, 1'b0, "abort_low");
    mem[1] = 32'h12FE3456;
    run_stream(2, 1'b0, "after_abort");

    fill_mem(1'b0);
    run_stream(100, 1'b0, "n100");
    run_stream(64, 1'b1, "n64");

    for (int r = 0; r < 6; r++) begin
      fill_mem(1'b0);
      if (r % 2 == 1) mem[$urandom_range(0, 20)][8 * $urandom_range(0, 3) +: 8] = 8'hFF;
      run_stream(int'($urandom_range(0, 24)), r[0], $sformatf("rand%0d", r));
    end

    // Reset in the middle of DATA abandons the stream without an end marker.
    fill_mem(1'b0);
    @(negedge clk);
    start_i     = 1'b1;
    num_words_i = 7'd5;
    @(negedge clk);
    start_i = 1'b0;
    repeat (6) @(negedge clk);
    check("pre_reset valid", 32'(byte_valid_o), 32'h1);
    reset = 1'b1;
    #1;
    check("midreset byte", 32'(byte_o), 32'h0);
    check("midreset valid", 32'(byte_valid_o), 32'h0);
    check("midreset busy", 32'(busy_o), 32'h0);
    check("midreset done", 32'(done_o), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    check("post_reset byte", 32'(byte_o), 32'h0);
    run_stream(5, 1'b0, "after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
